// File: rtl/spi_pkg.sv
// Types and helpers shared by the SPI register peripheral and its synchroniser.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, FULL, OVER} state_t;

    localparam logic RW_WRITE = 1'b1;

    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle: the controller drives ncs/sclk/copi, the peripheral drives cipo and its pad enable.
interface spi_reg_peripheral_if;

    logic ncs;
    logic sclk;
    logic copi;
    logic cipo;
    logic cipo_oe;

    modport master (output ncs, output sclk, output copi, input cipo, input cipo_oe);
    modport slave  (input ncs, input sclk, input copi, output cipo, output cipo_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a history flop for edge detection.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~hist_q;
    assign fall  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 peripheral with a small register bank; writes commit only when nCS closes a full frame.
module spi_reg_peripheral
    import spi_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_reg_peripheral_if.slave          spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         busy,
    output logic                         frame_err
);

    localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
    localparam int SH_W    = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    logic ncs_lvl_unused, ncs_rise, ncs_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise_unused, copi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(spi.ncs),
        .level(ncs_lvl_unused), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi.sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(spi.copi),
        .level(copi_lvl), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_inc;
    logic [SH_W-1:0]     sh, sh_nxt;
    logic [DATA_W-1:0]   rd_sh, rd_word;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic                rw_q;
    logic                cipo_q;
    logic                cmt_vld;
    logic [ADDR_W-1:0]   cmt_addr;
    logic [DATA_W-1:0]   cmt_data;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    // A closing nCS edge pre-empts any sclk edge seen in the same cycle.
    logic frame_end, sclk_rise_ok, sclk_fall_ok, addr_done;

    assign frame_end    = (state != IDLE) && ncs_rise;
    assign sclk_rise_ok = sclk_rise && !ncs_rise;
    assign sclk_fall_ok = sclk_fall && !ncs_rise;
    assign cnt_inc      = cnt + CNT_W'(1);
    assign sh_nxt       = {sh[SH_W-2:0], copi_lvl};
    assign addr_nxt     = sh_nxt[ADDR_W-1:0];
    assign addr_done    = (state == ADDR) && sclk_rise_ok && (cnt_inc == CNT_W'(1 + ADDR_W));

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (32'(addr_nxt) == 32'(i)) rd_word = regs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_end) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (ncs_fall) state_nxt = ADDR;
                ADDR:    if (addr_done) state_nxt = DATA;
                DATA:    if (sclk_rise_ok && cnt_inc == CNT_W'(FRAME_W)) state_nxt = FULL;
                FULL:    if (sclk_rise_ok) state_nxt = OVER;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sh     <= '0;
            rd_sh  <= '0;
            addr_q <= '0;
            rw_q   <= 1'b0;
            cipo_q <= 1'b0;
        end else begin
            if (state == IDLE && ncs_fall) begin
                cnt <= '0;
                sh  <= '0;
            end else if ((state == ADDR || state == DATA) && sclk_rise_ok) begin
                cnt <= cnt_inc;
                sh  <= sh_nxt;
            end
            if (addr_done) begin
                addr_q <= addr_nxt;
                rw_q   <= sh_nxt[ADDR_W];
                rd_sh  <= (sh_nxt[ADDR_W] == RW_WRITE || !in_range(addr_nxt)) ? '0 : rd_word;
            end
            if (state == DATA && sclk_fall_ok) begin
                cipo_q <= rd_sh[DATA_W-1];
                rd_sh  <= {rd_sh[DATA_W-2:0], 1'b0};
            end else if (state_nxt == IDLE) begin
                cipo_q <= 1'b0;
            end
        end
    end

    // Commit stage: frame outcome is latched on the nCS edge and applied one clock later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmt_vld   <= 1'b0;
            cmt_addr  <= '0;
            cmt_data  <= '0;
            frame_err <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            cmt_vld   <= 1'b0;
            frame_err <= 1'b0;
            if (frame_end) begin
                if (state == FULL) begin
                    if (rw_q == RW_WRITE && in_range(addr_q)) begin
                        cmt_vld  <= 1'b1;
                        cmt_addr <= addr_q;
                        cmt_data <= sh[DATA_W-1:0];
                    end
                end else begin
                    frame_err <= 1'b1;
                end
            end
            wr_pulse <= cmt_vld;
            if (cmt_vld) begin
                wr_addr <= cmt_addr;
                for (int i = 0; i < NUM_REGS; i++)
                    if (32'(cmt_addr) == 32'(i)) regs[i] <= cmt_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

    assign busy        = (state != IDLE);
    assign spi.cipo    = cipo_q;
    assign spi.cipo_oe = (state == DATA || state == FULL || state == OVER) && (rw_q != RW_WRITE);

endmodule
